crosshair_shooter: RTL and testbench
====================================

Name: crosshair_shooter

Overview:
- Player-side counterpart to the moving targets: produces the crosshair position and the `shoot` strobe that the targets consume.
- Also produces the crosshair draw flags for the VGA mux, ammo and kill bookkeeping for the score display.
- Inputs: DE2 push-buttons (active-low), VGA scan coordinates, and the aggregated 18-bit `is_dead` vector.
- Outputs drive `xl_target`/`yt_target`/`shoot` of every target instance.

Parameters:
- XSTART, 10'd316: crosshair upper-left x after reset.
- YSTART, 10'd236: crosshair upper-left y after reset.
- CSIZE, 10'd8: crosshair width and height; matches the 8-pixel hit window of the targets.
- STEP, 10'd4: pixels moved per movement tick.
- LEFT_BOUND, 10'd0 / RIGHT_BOUND, 10'd640 / TOP_BOUND, 10'd0 / BOTTOM_BOUND, 10'd480: movement limits.
- MOVE_DIV, 32'd2500000: clk cycles per movement tick.
- SHOT_LEN, 8'd4: cycles `shoot` is held high per shot.
- COOLDOWN, 32'd12500000: cycles after a shot before the next trigger is accepted.
- MAX_AMMO, 5'd20: shots per game.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous active-low reset
- x  in  10  VGA current pixel x
- y  in  10  VGA current pixel y
- key_left  in  1  active-low button
- key_right  in  1  active-low button
- key_up  in  1  active-low button
- key_down  in  1  active-low button
- key_fire  in  1  active-low trigger
- is_dead  in  18  dead flags of all targets
- xl_target  out  10  crosshair upper-left x
- yt_target  out  10  crosshair upper-left y
- shoot  out  1  shot strobe to targets
- crosshairx  out  1  x within crosshair
- crosshairy  out  1  y within crosshair
- ammo  out  5  shots remaining
- kills  out  5  targets killed
- out_of_ammo  out  1  high when ammo==0 and FSM in EMPTY

Behaviour:
- Reset (rst==0, async):
  - xl_target=XSTART, yt_target=YSTART, ammo=MAX_AMMO.
  - shoot=0, kills=0, crosshairx/crosshairy=0, out_of_ammo=0.
  - All counters and synchronizers clear; FSM enters IDLE.
- Input conditioning:
  - Every key goes through a 2-flop synchronizer and is inverted to active-high.
  - key_fire additionally gets a rising-edge detector; `fire_edge` is a 1-cycle pulse on press.
  - Holding the trigger does not auto-fire.
- Movement counter:
  - Free-running; wraps to 0 at MOVE_DIV and emits `move_tick` for 1 cycle.
  - Movement runs independently of the fire FSM, including during SHOT and COOL.
- Horizontal move, on move_tick:
  - left only: xl_target -= STEP unless xl_target < LEFT_BOUND+STEP, else xl_target=LEFT_BOUND.
  - right only: xl_target += STEP unless xl_target+CSIZE+STEP > RIGHT_BOUND, else xl_target=RIGHT_BOUND-CSIZE.
  - left and right together: no horizontal move.
- Vertical move: same rules with up/down, TOP_BOUND/BOTTOM_BOUND and yt_target.
- Width rule: all position arithmetic is 10-bit with the clamp compare done before the subtract, so underflow never occurs.
- Draw flags: registered, 1-cycle latency; crosshairx=(xl_target<=x && x<xl_target+CSIZE), crosshairy likewise for y. Both are forced 0 in EMPTY.
- Fire FSM:
  - IDLE: on fire_edge with ammo>0 → SHOT; ammo decrements on the transition edge; shot counter loads SHOT_LEN. fire_edge with ammo==0 is ignored.
  - SHOT: shoot=1 (registered) for exactly SHOT_LEN cycles, then → COOL. xl_target/yt_target may still move during SHOT; targets see the live position.
  - COOL: shoot=0; counts COOLDOWN cycles, then → IDLE if ammo>0, else → EMPTY. fire_edge during SHOT/COOL is dropped, not queued.
  - EMPTY: terminal until reset; shoot=0, out_of_ammo=1.
  - Undefined encoding → IDLE.
- Kill counting:
  - is_dead is registered into dead_q each cycle.
  - kills += popcount(is_dead & ~dead_q), saturating at 18.
  - Multiple new deaths in one cycle all count. Bits that fall back to 0 are ignored.
  - kills keeps updating in EMPTY.
- Reset mid-SHOT: shoot drops to 0 asynchronously; ammo restores to MAX_AMMO.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, SHOT, COOL, EMPTY) and the screen constants 640/480, which are also used by the targets and the VGA driver.
- One sub-module: `key_sync_edge`, a 2-flop synchronizer plus active-low inversion plus rising-edge pulse. It is instantiated five times; only the fire instance uses the edge output.

Test Plan (MOVE_DIV=10, COOLDOWN=20, SHOT_LEN=4, MAX_AMMO=3):
- Reset with no keys → xl_target=316, yt_target=236, ammo=3, kills=0, shoot=0 for 200 cycles.
- key_right held 5 ticks → xl_target=336. Then at xl_target=630, one more tick → clamps to 632 and holds.
- key_left and key_up held at xl_target=2, yt_target=0 → xl_target=0, yt_target stays 0, no wrap to 1020.
- Single fire press → shoot high exactly 4 cycles starting 3 cycles after the press (sync+edge+FSM), ammo 3→2. A second press 10 cycles later is ignored, with no shoot.
- Three valid shots → ammo=0, out_of_ammo=1 after cooldown. A fourth press gives no shoot. crosshairx/crosshairy=0 with x,y inside the box.
- is_dead 0→18'h00005 in one cycle, then →18'h00007 → kills 0→2→3. Then is_dead→0 → kills stays 3.

Source files
------------

// File: rtl/crosshair_shooter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crosshair_shooter_pkg
// Brief    : Shared fire-FSM encoding, screen constants and kill popcount.
// Revision : 1.0
// ============================================================================
package crosshair_shooter_pkg;

    localparam logic [9:0] c_SCREEN_W  = 10'd640;
    localparam logic [9:0] c_SCREEN_H  = 10'd480;
    localparam logic [4:0] c_MAX_KILLS = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOT  = 2'd1,
        ST_COOL  = 2'd2,
        ST_EMPTY = 2'd3
    } fire_state_t;

    function automatic logic [4:0] popcount18(input logic [17:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 18; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crosshair_shooter_key_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : key_sync_edge
// Brief    : 2-flop synchronizer for an active-low key, active-high level and
//            single-cycle press pulse.
// Revision : 1.0
// ============================================================================
module key_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Inverted ahead of the flops so the cleared state means "not pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= ~i_key_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/crosshair_shooter.sv
`default_nettype none
// ============================================================================
// Module   : crosshair_shooter
// Brief    : Crosshair movement, shot strobe/ammo FSM, draw flags and kill count.
// Revision : 1.0
// ============================================================================
module crosshair_shooter
    import crosshair_shooter_pkg::*;
#(
    parameter logic [9:0]  XSTART       = 10'd316,
    parameter logic [9:0]  YSTART       = 10'd236,
    parameter logic [9:0]  CSIZE        = 10'd8,
    parameter logic [9:0]  STEP         = 10'd4,
    parameter logic [9:0]  LEFT_BOUND   = 10'd0,
    parameter logic [9:0]  RIGHT_BOUND  = c_SCREEN_W,
    parameter logic [9:0]  TOP_BOUND    = 10'd0,
    parameter logic [9:0]  BOTTOM_BOUND = c_SCREEN_H,
    parameter logic [31:0] MOVE_DIV     = 32'd2500000,
    parameter logic [7:0]  SHOT_LEN     = 8'd4,
    parameter logic [31:0] COOLDOWN     = 32'd12500000,
    parameter logic [4:0]  MAX_AMMO     = 5'd20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_fire,
    input  logic [17:0] is_dead,
    output logic [9:0]  xl_target,
    output logic [9:0]  yt_target,
    output logic        shoot,
    output logic        crosshairx,
    output logic        crosshairy,
    output logic [4:0]  ammo,
    output logic [4:0]  kills,
    output logic        out_of_ammo
);

    logic [4:0] w_keys_n;
    logic [4:0] w_level;
    logic [4:0] w_rise;
    logic       w_unused;

    assign w_keys_n = {key_fire, key_down, key_up, key_right, key_left};

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_keys
            key_sync_edge u_sync (
                .clk     (clk),
                .rst_n   (rst),
                .i_key_n (w_keys_n[gi]),
                .o_level (w_level[gi]),
                .o_rise  (w_rise[gi])
            );
        end
    endgenerate

    // Only the fire key needs its press pulse; the others are level-driven.
    assign w_unused = &{1'b0, w_rise[3:0], w_level[4]};

    logic w_left, w_right, w_up, w_down, w_fire_edge;
    assign w_left      = w_level[0];
    assign w_right     = w_level[1];
    assign w_up        = w_level[2];
    assign w_down      = w_level[3];
    assign w_fire_edge = w_rise[4];

    logic [31:0] r_move_cnt;
    logic        w_move_tick;
    assign w_move_tick = (r_move_cnt == MOVE_DIV - 32'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             r_move_cnt <= 32'd0;
        else if (w_move_tick) r_move_cnt <= 32'd0;
        else                  r_move_cnt <= r_move_cnt + 32'd1;
    end

    logic [9:0] r_x, r_y, w_x_nxt, w_y_nxt;

    // Bounds are compared before stepping so the 10-bit position never wraps.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_move_tick) begin
            if (w_left && !w_right)
                w_x_nxt = (r_x < LEFT_BOUND + STEP) ? LEFT_BOUND : r_x - STEP;
            else if (w_right && !w_left)
                w_x_nxt = (r_x + CSIZE + STEP > RIGHT_BOUND) ? RIGHT_BOUND - CSIZE : r_x + STEP;
            if (w_up && !w_down)
                w_y_nxt = (r_y < TOP_BOUND + STEP) ? TOP_BOUND : r_y - STEP;
            else if (w_down && !w_up)
                w_y_nxt = (r_y + CSIZE + STEP > BOTTOM_BOUND) ? BOTTOM_BOUND - CSIZE : r_y + STEP;
        end
    end

    fire_state_t r_state, w_state_nxt;
    logic [7:0]  r_shot_cnt, w_shot_nxt;
    logic [31:0] r_cool_cnt, w_cool_nxt;
    logic [4:0]  r_ammo, w_ammo_nxt;
    logic        r_shoot;

    always_comb begin
        w_state_nxt = r_state;
        w_shot_nxt  = r_shot_cnt;
        w_cool_nxt  = r_cool_cnt;
        w_ammo_nxt  = r_ammo;
        case (r_state)
            ST_IDLE: begin
                if (w_fire_edge && (r_ammo != 5'd0)) begin
                    w_state_nxt = ST_SHOT;
                    w_shot_nxt  = SHOT_LEN;
                    w_ammo_nxt  = r_ammo - 5'd1;
                end
            end
            ST_SHOT: begin
                if (r_shot_cnt <= 8'd1) begin
                    w_state_nxt = ST_COOL;
                    w_cool_nxt  = COOLDOWN;
                end else begin
                    w_shot_nxt  = r_shot_cnt - 8'd1;
                end
            end
            ST_COOL: begin
                if (r_cool_cnt <= 32'd1)
                    w_state_nxt = (r_ammo != 5'd0) ? ST_IDLE : ST_EMPTY;
                else
                    w_cool_nxt  = r_cool_cnt - 32'd1;
            end
            ST_EMPTY: w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    logic [17:0] r_dead_q;
    logic [4:0]  r_kills;
    logic [5:0]  w_kill_sum;
    logic        r_chx, r_chy;

    assign w_kill_sum = {1'b0, r_kills} + {1'b0, popcount18(is_dead & ~r_dead_q)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shot_cnt <= 8'd0;
            r_cool_cnt <= 32'd0;
            r_ammo     <= MAX_AMMO;
            r_shoot    <= 1'b0;
            r_x        <= XSTART;
            r_y        <= YSTART;
            r_chx      <= 1'b0;
            r_chy      <= 1'b0;
            r_dead_q   <= 18'd0;
            r_kills    <= 5'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_shot_cnt <= w_shot_nxt;
            r_cool_cnt <= w_cool_nxt;
            r_ammo     <= w_ammo_nxt;
            r_shoot    <= (w_state_nxt == ST_SHOT);
            r_x        <= w_x_nxt;
            r_y        <= w_y_nxt;
            r_chx      <= (r_state != ST_EMPTY) && (r_x <= x) && (x < r_x + CSIZE);
            r_chy      <= (r_state != ST_EMPTY) && (r_y <= y) && (y < r_y + CSIZE);
            r_dead_q   <= is_dead;
            r_kills    <= (w_kill_sum > {1'b0, c_MAX_KILLS}) ? c_MAX_KILLS : w_kill_sum[4:0];
        end
    end

    assign xl_target   = r_x;
    assign yt_target   = r_y;
    assign shoot       = r_shoot;
    assign crosshairx  = r_chx;
    assign crosshairy  = r_chy;
    assign ammo        = r_ammo;
    assign kills       = r_kills;
    assign out_of_ammo = (r_state == ST_EMPTY) && (r_ammo == 5'd0);

endmodule
`default_nettype wire

// File: tb/tb_crosshair_shooter.sv
`default_nettype none
// ============================================================================
// Module   : tb_crosshair_shooter
// Brief    : Scoreboard bench for crosshair_shooter with directed key/death vectors.
// Revision : 1.0
// ============================================================================
module tb_crosshair_shooter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        key_left = 1'b1, key_right = 1'b1, key_up = 1'b1, key_down = 1'b1, key_fire = 1'b1;
    logic [17:0] is_dead = 18'd0;
    logic [9:0]  xl_target, yt_target;
    logic        shoot, crosshairx, crosshairy, out_of_ammo;
    logic [4:0]  ammo, kills;

    crosshair_shooter #(
        .MOVE_DIV (32'd10),
        .SHOT_LEN (8'd4),
        .COOLDOWN (32'd20),
        .MAX_AMMO (5'd3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_fire    (key_fire),
        .is_dead     (is_dead),
        .xl_target   (xl_target),
        .yt_target   (yt_target),
        .shoot       (shoot),
        .crosshairx  (crosshairx),
        .crosshairy  (crosshairy),
        .ammo        (ammo),
        .kills       (kills),
        .out_of_ammo (out_of_ammo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [9:0] px; logic [9:0] py; } pos_t;
    typedef struct { int start; logic [4:0] ammo_after; } shot_t;
    pos_t       exp_pos_q[$];
    shot_t      exp_shot_q[$];
    logic [4:0] exp_kill_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        failures++;
        $display("FAIL %s: got=%0d want=none (t=%0t)", name, act, $time);
    endtask

    // Position monitor: every position change must match the next queued position.
    logic [9:0] prev_x = 10'd316, prev_y = 10'd236;
    always @(negedge clk) begin
        if (!rst) begin
            prev_x = xl_target;
            prev_y = yt_target;
        end else if (xl_target !== prev_x || yt_target !== prev_y) begin
            if (exp_pos_q.size() == 0) begin
                check("pos_unexpected", {12'd0, xl_target, yt_target}, {12'd0, prev_x, prev_y});
            end else begin
                pos_t e;
                e = exp_pos_q.pop_front();
                check("pos_x", {22'd0, xl_target}, {22'd0, e.px});
                check("pos_y", {22'd0, yt_target}, {22'd0, e.py});
            end
            prev_x = xl_target;
            prev_y = yt_target;
        end
    end

    // Shot monitor: each completed shoot pulse is checked for start, length and ammo.
    bit in_shot = 1'b0;
    int sh_start = 0, sh_len = 0;
    always @(negedge clk) begin
        if (!rst) begin
            in_shot = 1'b0;
        end else if (shoot === 1'b1 && !in_shot) begin
            in_shot  = 1'b1;
            sh_start = cyc;
            sh_len   = 1;
        end else if (shoot === 1'b1) begin
            sh_len++;
        end else if (in_shot) begin
            in_shot = 1'b0;
            if (exp_shot_q.size() == 0) begin
                fail_now("shot_unexpected_start", sh_start);
            end else begin
                shot_t s;
                s = exp_shot_q.pop_front();
                check("shot_start", sh_start, s.start);
                check("shot_len", sh_len, 4);
                check("shot_ammo", {27'd0, ammo}, {27'd0, s.ammo_after});
            end
        end
    end

    logic [4:0] prev_k = 5'd0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_k = kills;
        end else if (kills !== prev_k) begin
            if (exp_kill_q.size() == 0)
                check("kills_unexpected", {27'd0, kills}, {27'd0, prev_k});
            else
                check("kills", {27'd0, kills}, {27'd0, exp_kill_q.pop_front()});
            prev_k = kills;
        end
    end

    task automatic press_fire(input bit expect_shot, input logic [4:0] ammo_after);
        shot_t s;
        @(posedge clk); #1;
        key_fire = 1'b0;
        if (expect_shot) begin
            s.start      = cyc + 3;
            s.ammo_after = ammo_after;
            exp_shot_q.push_back(s);
        end
        repeat (5) @(posedge clk);
        #1 key_fire = 1'b1;
    endtask

    initial begin
        pos_t p;
        #3 rst = 1'b0;
        #1;
        check("rst_xl", {22'd0, xl_target}, 32'd316);
        check("rst_yt", {22'd0, yt_target}, 32'd236);
        check("rst_ammo", {27'd0, ammo}, 32'd3);
        check("rst_kills", {27'd0, kills}, 32'd0);
        check("rst_shoot", {31'd0, shoot}, 32'd0);
        check("rst_chx", {31'd0, crosshairx}, 32'd0);
        check("rst_chy", {31'd0, crosshairy}, 32'd0);
        check("rst_ooa", {31'd0, out_of_ammo}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        repeat (200) @(posedge clk);
        check("idle_xl", {22'd0, xl_target}, 32'd316);
        check("idle_ammo", {27'd0, ammo}, 32'd3);

        // Opposing keys cancel; any motion is caught by the position monitor.
        #1 key_left = 1'b0; key_right = 1'b0;
        repeat (50) @(posedge clk);
        #1 key_left = 1'b1; key_right = 1'b1;
        repeat (5) @(posedge clk);

        for (int k = 1; k <= 79; k++) begin
            p.px = 10'(316 + 4 * k);
            p.py = 10'd236;
            exp_pos_q.push_back(p);
        end
        #1 key_right = 1'b0;
        repeat (850) @(posedge clk);
        #1 key_right = 1'b1;
        repeat (5) @(posedge clk);
        check("right_clamp_xl", {22'd0, xl_target}, 32'd632);

        for (int k = 1; k <= 158; k++) begin
            p.px = 10'(632 - 4 * k);
            p.py = (4 * k >= 236) ? 10'd0 : 10'(236 - 4 * k);
            exp_pos_q.push_back(p);
        end
        #1 key_left = 1'b0; key_up = 1'b0;
        repeat (1700) @(posedge clk);
        #1 key_left = 1'b1; key_up = 1'b1;
        repeat (5) @(posedge clk);
        check("left_clamp_xl", {22'd0, xl_target}, 32'd0);
        check("up_clamp_yt", {22'd0, yt_target}, 32'd0);

        #1 x = 10'd3; y = 10'd5;
        repeat (2) @(posedge clk); #1;
        check("chx_in", {31'd0, crosshairx}, 32'd1);
        check("chy_in", {31'd0, crosshairy}, 32'd1);
        x = 10'd8; y = 10'd7;
        repeat (2) @(posedge clk); #1;
        check("chx_edge_out", {31'd0, crosshairx}, 32'd0);
        check("chy_edge_in", {31'd0, crosshairy}, 32'd1);
        x = 10'd7; y = 10'd8;
        repeat (2) @(posedge clk); #1;
        check("chx_edge_in", {31'd0, crosshairx}, 32'd1);
        check("chy_edge_out", {31'd0, crosshairy}, 32'd0);

        press_fire(1'b1, 5'd2);
        repeat (4) @(posedge clk);
        press_fire(1'b0, 5'd0);
        repeat (30) @(posedge clk);
        check("ammo_after1", {27'd0, ammo}, 32'd2);
        check("ooa_after1", {31'd0, out_of_ammo}, 32'd0);
        press_fire(1'b1, 5'd1);
        repeat (40) @(posedge clk);
        press_fire(1'b1, 5'd0);
        repeat (40) @(posedge clk);
        check("ooa_empty", {31'd0, out_of_ammo}, 32'd1);
        check("ammo_empty", {27'd0, ammo}, 32'd0);
        press_fire(1'b0, 5'd0);
        repeat (20) @(posedge clk);
        #1 x = 10'd3; y = 10'd5;
        repeat (2) @(posedge clk); #1;
        check("chx_empty", {31'd0, crosshairx}, 32'd0);
        check("chy_empty", {31'd0, crosshairy}, 32'd0);

        exp_kill_q.push_back(5'd2);
        is_dead = 18'h00005;
        repeat (3) @(posedge clk); #1;
        exp_kill_q.push_back(5'd3);
        is_dead = 18'h00007;
        repeat (3) @(posedge clk); #1;
        is_dead = 18'h00000;
        repeat (3) @(posedge clk); #1;
        check("kills_hold", {27'd0, kills}, 32'd3);
        exp_kill_q.push_back(5'd18);
        is_dead = 18'h3FFFF;
        repeat (3) @(posedge clk); #1;
        is_dead = 18'h00000;
        repeat (3) @(posedge clk); #1;
        is_dead = 18'h3FFFF;
        repeat (3) @(posedge clk); #1;
        check("kills_sat", {27'd0, kills}, 32'd18);
        is_dead = 18'h00000;

        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 key_fire = 1'b0;
        begin
            int waited;
            waited = 0;
            while (shoot !== 1'b1 && waited < 10) begin
                @(negedge clk);
                waited++;
            end
            if (shoot !== 1'b1) fail_now("midshot_no_shoot", waited);
        end
        #2 rst = 1'b0;
        #1;
        check("midshot_shoot", {31'd0, shoot}, 32'd0);
        check("midshot_ammo", {27'd0, ammo}, 32'd3);
        check("midshot_xl", {22'd0, xl_target}, 32'd316);
        check("midshot_kills", {27'd0, kills}, 32'd0);
        key_fire = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("post_rst_ammo", {27'd0, ammo}, 32'd3);

        check("pos_q_empty", exp_pos_q.size(), 0);
        check("shot_q_empty", exp_shot_q.size(), 0);
        check("kill_q_empty", exp_kill_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
